// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI-Lite master: converts a command/response handshake into
// one complete AXI-Lite read or write transaction at a time; all outputs registered.
module axil_master_cmd #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [2:0]                    cmd_prot,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                    m_axil_awprot,
    output logic                          m_axil_awvalid,
    input  logic                          m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                          m_axil_wvalid,
    input  logic                          m_axil_wready,
    input  logic [1:0]                    m_axil_bresp,
    input  logic                          m_axil_bvalid,
    output logic                          m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                      r_state, w_state_next;
    logic                        r_cmd_ready, w_cmd_ready_next;
    logic                        r_awvalid, w_awvalid_next;
    logic                        r_wvalid, w_wvalid_next;
    logic                        r_bready, w_bready_next;
    logic                        r_arvalid, w_arvalid_next;
    logic                        r_rready, w_rready_next;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_next;
    logic [2:0]                  r_awprot, w_awprot_next;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
    logic [STRB_W-1:0]           r_wstrb, w_wstrb_next;
    logic [AXI_ADDR_WIDTH-1:0]   r_araddr, w_araddr_next;
    logic [2:0]                  r_arprot, w_arprot_next;
    logic                        r_rsp_valid, w_rsp_valid_next;
    logic                        r_rsp_write, w_rsp_write_next;
    logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_next;
    logic [1:0]                  r_rsp_resp, w_rsp_resp_next;
    logic                        w_aw_done, w_w_done;

    // A channel counts as done once its valid is low or is handshaking this cycle
    assign w_aw_done = !r_awvalid || m_axil_awready;
    assign w_w_done  = !r_wvalid  || m_axil_wready;

    always_comb begin
        w_state_next     = r_state;
        w_cmd_ready_next = r_cmd_ready;
        w_awvalid_next   = r_awvalid;
        w_wvalid_next    = r_wvalid;
        w_bready_next    = r_bready;
        w_arvalid_next   = r_arvalid;
        w_rready_next    = r_rready;
        w_awaddr_next    = r_awaddr;
        w_awprot_next    = r_awprot;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        w_araddr_next    = r_araddr;
        w_arprot_next    = r_arprot;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_write_next = r_rsp_write;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_resp_next  = r_rsp_resp;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_next = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_next = 1'b0;
                    if (cmd_write) begin
                        w_awaddr_next  = cmd_addr;
                        w_awprot_next  = cmd_prot;
                        w_wdata_next   = cmd_wdata;
                        w_wstrb_next   = cmd_wstrb;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                        w_state_next   = S_WR_REQ;
                    end else begin
                        w_araddr_next  = cmd_addr;
                        w_arprot_next  = cmd_prot;
                        w_arvalid_next = 1'b1;
                        w_state_next   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (r_awvalid && m_axil_awready) w_awvalid_next = 1'b0;
                if (r_wvalid && m_axil_wready)   w_wvalid_next  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_next = 1'b1;
                    w_state_next  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axil_bvalid && r_bready) begin
                    w_bready_next    = 1'b0;
                    w_rsp_resp_next  = m_axil_bresp;
                    w_rsp_rdata_next = '0;
                    w_rsp_write_next = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (r_arvalid && m_axil_arready) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                    w_state_next   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (m_axil_rvalid && r_rready) begin
                    w_rready_next    = 1'b0;
                    w_rsp_rdata_next = m_axil_rdata;
                    w_rsp_resp_next  = m_axil_rresp;
                    w_rsp_write_next = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                // Unused encodings recover to a quiet IDLE
                w_state_next     = S_IDLE;
                w_cmd_ready_next = 1'b0;
                w_awvalid_next   = 1'b0;
                w_wvalid_next    = 1'b0;
                w_bready_next    = 1'b0;
                w_arvalid_next   = 1'b0;
                w_rready_next    = 1'b0;
                w_rsp_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awprot    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_arprot    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_awvalid   <= w_awvalid_next;
            r_wvalid    <= w_wvalid_next;
            r_bready    <= w_bready_next;
            r_arvalid   <= w_arvalid_next;
            r_rready    <= w_rready_next;
            r_awaddr    <= w_awaddr_next;
            r_awprot    <= w_awprot_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_araddr    <= w_araddr_next;
            r_arprot    <= w_arprot_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_write <= w_rsp_write_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_resp  <= w_rsp_resp_next;
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_write      = r_rsp_write;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_awprot  = r_awprot;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_araddr;
    assign m_axil_arprot  = r_arprot;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Directed testbench for axil_master_cmd; the bench plays both requester and AXI-Lite slave.
module tb_axil_master_cmd;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checkCount = 0;
    int failCount  = 0;

    axil_master_cmd dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge, where outputs are sampled and inputs driven
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        cmd_prot  = prot;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        tick(); tick();

        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        checkOutput("rst_payload", {awaddr, wdata}, 0);
        aresetn = 1'b1;
        tick();
        checkOutput("rel_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        awready = 1'b1; wready = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        checkOutput("w1_valids", {awvalid, wvalid, bready, cmd_ready}, 4'b1100);
        checkOutput("w1_awaddr", awaddr, 32'h10);
        checkOutput("w1_wdata", wdata, 32'hDEADBEEF);
        checkOutput("w1_wstrb_prot", {wstrb, awprot}, {4'hF, 3'b010});
        tick();
        checkOutput("w1_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("w1_rsp_valid", rsp_valid, 1);
        checkOutput("w1_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        checkOutput("w1_bready_low", bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("w1_done", {rsp_valid, cmd_ready}, 2'b01);

        // Write with wready arriving three cycles after the AW handshake
        awready = 1'b1; wready = 1'b0;
        applyStimulus(1'b1, 32'h44, 32'hCAFE0001, 4'h3, 3'b000);
        checkOutput("w2_both_valid", {awvalid, wvalid}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("w2_hold%0d", i), {awvalid, wvalid, bready}, 3'b010);
            checkOutput($sformatf("w2_wdata%0d", i), {wdata, wstrb}, {32'hCAFE0001, 4'h3});
        end
        wready = 1'b1;
        tick();
        checkOutput("w2_bready", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b01;
        tick();
        bvalid = 1'b0;
        checkOutput("w2_rsp", {rsp_valid, rsp_write, rsp_resp, bready}, {1'b1, 1'b1, 2'b01, 1'b0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("w2_single_rsp", {rsp_valid, cmd_ready, bready}, 3'b010);

        // Read with rvalid delayed two cycles, then response held for five cycles
        arready = 1'b1; awready = 1'b0; wready = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 3'b001);
        checkOutput("r1_arvalid", {arvalid, awvalid, wvalid}, 3'b100);
        checkOutput("r1_araddr", {araddr, arprot}, {32'h20, 3'b001});
        tick();
        checkOutput("r1_rready", {arvalid, rready}, 2'b01);
        tick(); tick();
        checkOutput("r1_wait", {rready, rsp_valid}, 2'b10);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFFFFFF;
        checkOutput("r1_rsp", {rsp_valid, rsp_write, rsp_resp, rready}, {1'b1, 1'b0, 2'b00, 1'b0});
        checkOutput("r1_rdata", rsp_rdata, 32'h12345678);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("hold_rsp%0d", i), {rsp_valid, rsp_rdata, cmd_ready, awvalid},
                        {1'b1, 32'h12345678, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("hold_release", {rsp_valid, cmd_ready, awvalid}, 3'b010);

        // Unmapped read answered with DECERR by the interconnect default slave
        cmd_write = 1'b0; cmd_addr = 32'hF000_0000;
        tick();
        cmd_valid = 1'b0;
        checkOutput("r2_arvalid", {arvalid, araddr}, {1'b1, 32'hF000_0000});
        tick();
        rvalid = 1'b1; rdata = 32'h0; rresp = 2'b11;
        tick();
        rvalid = 1'b0;
        checkOutput("r2_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'h0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("r2_done", {rsp_valid, cmd_ready}, 2'b01);

        // Reset while a write is still waiting for its handshakes
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        applyStimulus(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'b000);
        checkOutput("rw_pending", {awvalid, wvalid}, 2'b11);
        aresetn = 1'b0;
        tick();
        checkOutput("rw_reset_valids", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid}, 0);
        checkOutput("rw_reset_payload", {awaddr, wdata}, 0);
        aresetn = 1'b1;
        tick();
        checkOutput("rw_release", {cmd_ready, awvalid, wvalid}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/axil_master_cmd.md
# axil_master_cmd

Single-outstanding AXI-Lite master that turns a simple command/response handshake into complete AXI-Lite read or write transactions. It sits upstream of the priority AXI-Lite interconnect as an initiator port, e.g. for register-access bridges and test sequencers. Slave responses, including DECERR from the interconnect's invalid-address responders, pass back to the requester unchanged.

## Interface
- AXI_DATA_WIDTH, 32, data width of wdata/rdata (multiple of 8)
- AXI_ADDR_WIDTH, 32, address width
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH  target address
- cmd_wdata  in  AXI_DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes (ignored for reads)
- cmd_prot  in  3  driven on awprot/arprot
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  AXI_DATA_WIDTH  read data; '0 for writes
- rsp_resp  out  2  bresp/rresp as returned by slave
- m_axil_awaddr/awprot/awvalid out, awready in: AW channel
- m_axil_wdata/wstrb/wvalid out, wready in: W channel
- m_axil_bresp/bvalid in, bready out: B channel
- m_axil_araddr/arprot/arvalid out, arready in: AR channel
- m_axil_rdata/rresp/rvalid in, rready out: R channel

## Operation
- All outputs registered. States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch addr/data/strb/prot/write, cmd_ready<=0; write -> WR_REQ with awvalid<=1, wvalid<=1; read -> RD_REQ with arvalid<=1.
- WR_REQ: AW and W complete independently. awvalid drops on the edge where awvalid&&awready; wvalid likewise. Payload held stable while its valid is high. When both handshakes are done (same or different cycles) -> WR_RESP, bready<=1.
- WR_RESP: on bvalid&&bready: bready<=0, rsp_resp<=bresp, rsp_rdata<='0, rsp_write<=1, rsp_valid<=1 -> RSP.
- RD_REQ: on arvalid&&arready: arvalid<=0, rready<=1 -> RD_RESP.
- RD_RESP: on rvalid&&rready: rready<=0, rsp_rdata<=rdata, rsp_resp<=rresp, rsp_write<=0, rsp_valid<=1 -> RSP.
- RSP: hold rsp_* stable until rsp_ready; then rsp_valid<=0, cmd_ready<=1 -> IDLE.
- Never asserts AW/W and AR concurrently; at most one transaction outstanding.
- Valids are never withdrawn before their handshake (AXI compliant); the block waits indefinitely on a silent slave. The interconnect default slave guarantees a response for unmapped addresses.
- rresp/bresp values are not interpreted; 2'b10/2'b11 are forwarded as-is.
- Unused encoding of the state register returns to IDLE with all valids/readies low.

## Timing
- Reset: cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata='0, rsp_resp=2'b00, all m_axil valid/ready=0, all m_axil payloads '0. cmd_ready rises on the first edge after aresetn goes high.
- Reset mid-transaction: all outputs return to reset values on that edge; the in-flight transaction is abandoned (system-level reset assumed).
- Command accepted at edge T: valid(s) high from T+1.
- Zero-wait slave write: AW/W handshake at T+1, bready high T+2, bvalid at T+2 -> rsp_valid at T+3. Read: arready at T+1, rready T+2, rvalid T+2 -> rsp_valid T+3.
- rsp_ready high at T+3 -> cmd_ready high at T+4; next command accepted no earlier than T+4. Minimum spacing 4 cycles.
- bvalid/rvalid arriving before bready/rready are high are held by the slave; the block samples only when its ready is high.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AW/W valid at T+1, bready at T+2, rsp_valid at T+3 with rsp_write=1, rsp_resp=2'b00, rsp_rdata=0.
- Write with wready delayed 3 cycles after awready -> awvalid drops after 1 cycle, wvalid held 4 cycles with data stable, single B handshake, one response.
- Read addr 0x20, slave returns 0x12345678 after 2-cycle rvalid delay -> rsp_rdata=0x12345678, rsp_resp=2'b00, arvalid low after handshake.
- Read of unmapped address through interconnect -> rsp_resp=2'b11, rsp_rdata=0.
- rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready stays 0, new cmd_valid ignored until 1 cycle after rsp_ready.
- aresetn asserted while wvalid pending -> all outputs at reset values next edge; cmd_ready=1 one edge after release.
